// File: rtl/evt2_pkg.sv
// Shared EVT 2.0 word layout, event type codes and decoder helper functions.
package evt2_pkg;

  localparam logic [3:0] EVT_CD_OFF      = 4'h0;
  localparam logic [3:0] EVT_CD_ON       = 4'h1;
  localparam logic [3:0] EVT_TIME_HIGH   = 4'h8;
  localparam logic [3:0] EVT_EXT_TRIGGER = 4'hA;
  localparam logic [3:0] EVT_OTHERS      = 4'hE;
  localparam logic [3:0] EVT_CONTINUED   = 4'hF;

  localparam int unsigned EVT_WORD_W     = 32;
  localparam int unsigned EVT_TYPE_W     = 4;
  localparam int unsigned EVT_TS_LSB_W   = 6;
  localparam int unsigned EVT_COORD_W    = 11;
  localparam int unsigned EVT_TH_W       = 28;
  localparam int unsigned EVT_FULL_TS_W  = EVT_TH_W + EVT_TS_LSB_W;

  localparam int unsigned EVT_Y_LSB      = 0;
  localparam int unsigned EVT_X_LSB      = EVT_Y_LSB + EVT_COORD_W;
  localparam int unsigned EVT_TS_LSB_LSB = EVT_X_LSB + EVT_COORD_W;
  localparam int unsigned EVT_TYPE_LSB   = EVT_TS_LSB_LSB + EVT_TS_LSB_W;
  localparam int unsigned EVT_TH_LSB     = 0;

  localparam int unsigned DEF_GRID_BITS  = 5;
  localparam int unsigned DEF_TS_BITS    = 16;

  typedef struct packed {
    logic [DEF_GRID_BITS-1:0] x;
    logic [DEF_GRID_BITS-1:0] y;
    logic                     pol;
    logic [DEF_TS_BITS-1:0]   ts;
  } grid_evt_t;

  // Downsample a raw coordinate and clamp it to the top grid cell.
  function automatic logic [EVT_COORD_W-1:0] grid_clamp(
    input logic [EVT_COORD_W-1:0] raw,
    input int unsigned            shift,
    input int unsigned            grid_bits
  );
    logic [EVT_COORD_W-1:0] g;
    logic [EVT_COORD_W-1:0] gmax;
    g    = raw >> shift;
    gmax = EVT_COORD_W'((1 << grid_bits) - 1);
    return (g > gmax) ? gmax : g;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module evt_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/evt2_stream_decoder.sv
// EVT 2.0 stream decoder: one decode register stage feeding an output FIFO,
// with ready/valid on both sides, polarity filtering and saturating statistics.
module evt2_stream_decoder
  import evt2_pkg::*;
#(
  parameter int unsigned GRID_BITS = 5,
  parameter int unsigned SENSOR_W  = 320,
  parameter int unsigned SENSOR_H  = 320,
  parameter int unsigned DS_SHIFT  = 3,
  parameter int unsigned TS_BITS   = 16,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_pol_en,
  output logic [GRID_BITS-1:0] m_x,
  output logic [GRID_BITS-1:0] m_y,
  output logic                 m_pol,
  output logic [TS_BITS-1:0]   m_ts,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          stat_events,
  output logic [15:0]          stat_oor,
  output logic [15:0]          stat_filtered
);

  localparam int unsigned EW = 2*GRID_BITS + 1 + TS_BITS;
  localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

  logic [EVT_TYPE_W-1:0]    evt_type;
  logic [EVT_TS_LSB_W-1:0]  ts_lsb;
  logic [EVT_COORD_W-1:0]   x_raw;
  logic [EVT_COORD_W-1:0]   y_raw;
  logic [EVT_TH_W-1:0]      th_payload;
  logic [EVT_TH_W-1:0]      time_high_reg;
  logic [EVT_FULL_TS_W-1:0] full_ts;

  logic accept;
  logic is_cd;
  logic is_th;
  logic oor;
  logic pol_pass;
  logic load;
  logic oor_hit;
  logic filt_hit;

  logic                 stage_valid;
  logic [GRID_BITS-1:0] stage_x;
  logic [GRID_BITS-1:0] stage_y;
  logic                 stage_pol;
  logic [TS_BITS-1:0]   stage_ts;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        occupancy;
  logic [EW-1:0]        fifo_rd_data;

  logic [GRID_BITS-1:0] head_x;
  logic [GRID_BITS-1:0] head_y;
  logic                 head_pol;
  logic [TS_BITS-1:0]   head_ts;

  assign evt_type   = s_data[EVT_TYPE_LSB   +: EVT_TYPE_W];
  assign ts_lsb     = s_data[EVT_TS_LSB_LSB +: EVT_TS_LSB_W];
  assign x_raw      = s_data[EVT_X_LSB      +: EVT_COORD_W];
  assign y_raw      = s_data[EVT_Y_LSB      +: EVT_COORD_W];
  assign th_payload = s_data[EVT_TH_LSB     +: EVT_TH_W];

  assign full_ts = {time_high_reg, ts_lsb};

  // Stage plus FIFO occupancy bounds acceptance, so a loaded stage always has a FIFO slot.
  assign occupancy = fifo_count + CW'(stage_valid);
  assign s_ready   = !rst && (occupancy < CW'(OUT_DEPTH));
  assign accept    = s_valid && s_ready;

  assign is_cd    = (evt_type == EVT_CD_OFF) || (evt_type == EVT_CD_ON);
  assign is_th    = (evt_type == EVT_TIME_HIGH);
  assign oor      = (32'(x_raw) >= 32'(SENSOR_W)) || (32'(y_raw) >= 32'(SENSOR_H));
  assign pol_pass = cfg_pol_en[evt_type[0]];

  assign load     = accept && is_cd && cfg_enable && !oor && pol_pass;
  assign oor_hit  = accept && is_cd && cfg_enable && oor;
  assign filt_hit = accept && is_cd && cfg_enable && !oor && !pol_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      time_high_reg <= '0;
    end else if (accept && is_th) begin
      time_high_reg <= th_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_x     <= '0;
      stage_y     <= '0;
      stage_pol   <= 1'b0;
      stage_ts    <= '0;
    end else begin
      stage_valid <= load;
      if (load) begin
        stage_x   <= GRID_BITS'(grid_clamp(x_raw, DS_SHIFT, GRID_BITS));
        stage_y   <= GRID_BITS'(grid_clamp(y_raw, DS_SHIFT, GRID_BITS));
        stage_pol <= evt_type[0];
        stage_ts  <= full_ts[TS_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_events   <= '0;
      stat_oor      <= '0;
      stat_filtered <= '0;
    end else begin
      if (fifo_push) stat_events   <= sat_inc16(stat_events);
      if (oor_hit)   stat_oor      <= sat_inc16(stat_oor);
      if (filt_hit)  stat_filtered <= sat_inc16(stat_filtered);
    end
  end

  assign fifo_pop  = m_valid && m_ready;
  assign fifo_push = stage_valid && (!fifo_full || fifo_pop);

  evt_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({stage_x, stage_y, stage_pol, stage_ts}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign {head_x, head_y, head_pol, head_ts} = fifo_rd_data;

  // FIFO storage is not reset; outputs read zero whenever nothing is valid.
  always_comb begin
    m_x   = '0;
    m_y   = '0;
    m_pol = 1'b0;
    m_ts  = '0;
    if (m_valid) begin
      m_x   = head_x;
      m_y   = head_y;
      m_pol = head_pol;
      m_ts  = head_ts;
    end
  end

endmodule

// File: tb/tb_evt2_stream_decoder.sv
// Scoreboard bench for evt2_stream_decoder; a second instance uses TS_BITS=24.
module tb_evt2_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_enable;
  logic [1:0]  cfg_pol_en;
  logic [4:0]  m_x, m_y;
  logic        m_pol;
  logic [15:0] m_ts;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] stat_events, stat_oor, stat_filtered;

  logic        s_ready24;
  logic [4:0]  m_x24, m_y24;
  logic        m_pol24;
  logic [23:0] m_ts24;
  logic        m_valid24;
  logic [15:0] stat_events24, stat_oor24, stat_filtered24;

  always #5 clk = ~clk;

  evt2_stream_decoder dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_enable(cfg_enable), .cfg_pol_en(cfg_pol_en),
    .m_x(m_x), .m_y(m_y), .m_pol(m_pol), .m_ts(m_ts), .m_valid(m_valid), .m_ready(m_ready),
    .stat_events(stat_events), .stat_oor(stat_oor), .stat_filtered(stat_filtered)
  );

  evt2_stream_decoder #(.TS_BITS(24)) dut24 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready24),
    .cfg_enable(cfg_enable), .cfg_pol_en(cfg_pol_en),
    .m_x(m_x24), .m_y(m_y24), .m_pol(m_pol24), .m_ts(m_ts24), .m_valid(m_valid24), .m_ready(m_ready),
    .stat_events(stat_events24), .stat_oor(stat_oor24), .stat_filtered(stat_filtered24)
  );

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic        pol;
    logic [33:0] ts;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [27:0] th_m;
  logic [15:0] ev_m, oor_m, filt_m;
  logic        hold_armed = 1'b0;
  logic [37:0] held;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cd(input logic pol, input logic [5:0] t,
                                     input int unsigned x, input int unsigned y);
    return {3'b000, pol, t, x[10:0], y[10:0]};
  endfunction

  function automatic logic [31:0] th(input logic [27:0] p);
    return {4'h8, p};
  endfunction

  function automatic logic [4:0] gmod(input logic [10:0] raw);
    logic [10:0] g;
    g = raw >> 3;
    return (g > 11'd31) ? 5'd31 : g[4:0];
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    sb.delete();
    th_m = '0; ev_m = '0; oor_m = '0; filt_m = '0;
  endtask

  task automatic model_accept(input logic [31:0] w);
    logic [3:0]  ty;
    logic [10:0] x, y;
    exp_t        n;
    ty = w[31:28];
    x  = w[21:11];
    y  = w[10:0];
    if (ty == 4'h8) begin
      th_m = w[27:0];
    end else if (ty <= 4'h1 && cfg_enable) begin
      if (x >= 11'd320 || y >= 11'd320) oor_m = sat(oor_m);
      else if (!cfg_pol_en[ty[0]]) filt_m = sat(filt_m);
      else begin
        n.x = gmod(x); n.y = gmod(y); n.pol = ty[0]; n.ts = {th_m, w[27:22]};
        sb.push_back(n);
        ev_m = sat(ev_m);
      end
    end
  endtask

  task automatic try_send(input logic [31:0] w, input int maxc, output bit ok);
    s_data  = w;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(w);
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    bit ok;
    try_send(w, 50, ok);
    check_eq("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      @(posedge clk); #1;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_events"},   64'(stat_events),     64'(ev_m));
    check_eq({tag, "_oor"},      64'(stat_oor),        64'(oor_m));
    check_eq({tag, "_filtered"}, 64'(stat_filtered),   64'(filt_m));
    check_eq({tag, "_events24"}, 64'(stat_events24),   64'(ev_m));
  endtask

  // Output monitor: scoreboard pops on handshakes, hold check while stalled.
  always @(negedge clk) begin
    if (hold_armed && m_valid)
      check_eq("hold_stable", 64'({m_x, m_y, m_pol, m_ts}), 64'(held[26:0]));
    hold_armed = m_valid && !m_ready && !rst;
    held       = 38'({m_x, m_y, m_pol, m_ts});
    if (m_valid && m_ready && !rst) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 64'({m_x, m_y, m_pol, m_ts}), 64'hDEAD_0000_0000_0000);
      end else begin
        e = sb.pop_front();
        check_eq("m_x",    64'(m_x),    64'(e.x));
        check_eq("m_y",    64'(m_y),    64'(e.y));
        check_eq("m_pol",  64'(m_pol),  64'(e.pol));
        check_eq("m_ts",   64'(m_ts),   64'(e.ts[15:0]));
        check_eq("m_ts24", 64'(m_ts24), 64'(e.ts[23:0]));
        check_eq("m_x24",  64'(m_x24),  64'(e.x));
      end
    end
  end

  initial begin
    int unsigned acc;
    bit          ok;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_enable = 1'b1; cfg_pol_en = 2'b11; m_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd0);
    check_eq("rst_m_ts",    64'(m_ts),    64'd0);
    check_stats("rst");
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Basic decode and latency
    send(th(28'd5));
    send(cd(1'b1, 6'h2A, 100, 300));
    check_eq("lat_stage_only", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_out_valid", 64'(m_valid), 64'd1);
    check_eq("basic_x",  64'(m_x),  64'd12);
    check_eq("basic_y",  64'(m_y),  64'd31);
    check_eq("basic_ts", 64'(m_ts), 64'h016A);
    drain();

    // Clamp and out-of-range
    send(cd(1'b1, 6'd5, 319, 255));
    send(cd(1'b0, 6'd6, 320, 10));
    drain();
    check_eq("oor_count", 64'(stat_oor), 64'd1);
    check_stats("clamp");

    // Backpressure: only OUT_DEPTH words fit
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(cd(1'(i), 6'(i + 3), i * 40, i * 30 + 7), 6, ok);
      if (ok) acc++;
    end
    check_eq("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk);
    check_eq("bp_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain();

    // Polarity filter
    cfg_pol_en = 2'b10;
    for (int i = 0; i < 6; i++) send(cd(1'(i), 6'(i), 8 * i + 1, 16 * i + 2));
    drain();
    check_eq("filtered_count", 64'(stat_filtered), 64'd3);
    check_stats("pol");

    // Disabled decode still tracks TIME_HIGH
    cfg_pol_en = 2'b11;
    cfg_enable = 1'b0;
    send(cd(1'b1, 6'd1, 10, 10));
    send(th(28'h123));
    send(cd(1'b0, 6'd2, 400, 20));
    cfg_enable = 1'b1;
    send(cd(1'b1, 6'h11, 50, 60));
    drain();
    check_stats("enable");

    // Wide timestamp
    send(th(28'h0ABCDEF));
    send(cd(1'b1, 6'h15, 200, 100));
    drain();

    // Saturation of stat_events
    for (int unsigned i = 0; i < 65540; i++)
      send(cd(1'(i), 6'(i), (i * 7) % 320, (i * 13) % 320));
    drain();
    check_eq("sat_events", 64'(stat_events), 64'hFFFF);
    check_stats("sat");

    // Reset mid-stream with buffered events
    m_ready = 1'b0;
    send(th(28'h777));
    for (int i = 0; i < 3; i++) send(cd(1'b1, 6'(i), 30 * i, 40 * i));
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_eq("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("mid_rst_m_x",     64'(m_x),     64'd0);
    check_eq("mid_rst_m_y",     64'(m_y),     64'd0);
    check_eq("mid_rst_m_pol",   64'(m_pol),   64'd0);
    check_eq("mid_rst_m_ts",    64'(m_ts),    64'd0);
    check_eq("mid_rst_s_ready", 64'(s_ready), 64'd0);
    check_stats("mid_rst");
    rst = 1'b0;
    m_ready = 1'b1;
    send(cd(1'b1, 6'h09, 16, 16));
    @(posedge clk); #1;
    check_eq("post_rst_ts", 64'(m_ts), 64'h9);
    drain();
    check_stats("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
